conv_window3x3: RTL and testbench
=================================

CONV_WINDOW3X3 -- requirements
Module: conv_window3x3

Interface
REQ-001 Parameter WIDTH, default 180, pixels per image line.
REQ-002 Parameter HEIGHT, default 180, lines per frame.
REQ-003 Parameter SHIFT, default 0, arithmetic right-shift applied to the accumulated sum.
REQ-004 Port pushpixel  input  1  clock; one clock, all state on rising edge.
REQ-005 Port reset  input  1  asynchronous, active-low reset.
REQ-006 Port in_valid  input  1  the three row taps carry one new image column this cycle.
REQ-007 Port w1  input  9  pixel of the oldest line (top row), unsigned.
REQ-008 Port w2  input  9  pixel of the middle line, unsigned.
REQ-009 Port w3  input  9  pixel of the newest line (bottom row), unsigned.
REQ-010 Port kernel  input  36  nine signed 4-bit coefficients; bits [4k+3:4k] = k(k), k0 top-left, row-major, k8 bottom-right.
REQ-011 Port out_valid  output  1  pix_out holds one convolution result.
REQ-012 Port pix_out  output  9  clamped result, unsigned.
REQ-013 Port frame_done  output  1  one-cycle pulse coincident with the last result of a frame.

Function
REQ-014 The block SHALL keep a 3x3 window register; each accepted column shifts the window one column left and loads {w1,w2,w3} into the rightmost column.
REQ-015 The block SHALL advance column counter col (0..WIDTH-1) on every accepted column, wrapping to 0 and incrementing row counter row (0..HEIGHT-1) at col=WIDTH-1.
REQ-016 At row=HEIGHT-1, col=WIDTH-1, both counters SHALL wrap to 0 (next frame).
REQ-017 A window SHALL be valid when the accepted column has col>=2 and row>=2; no window SHALL straddle a line wrap.
REQ-018 Cycles with in_valid=0 SHALL leave window, counters and kernel unchanged; gaps of any length are legal.
REQ-019 The kernel SHALL be latched when the column with col=0, row=0 is accepted and held for the whole frame; mid-frame kernel changes SHALL have no effect.
REQ-020 Stage 1 SHALL form nine signed 14-bit products pixel x coefficient.
REQ-021 Stage 2 SHALL sum the nine products into an 18-bit signed value without overflow.
REQ-022 Stage 3 SHALL shift the sum arithmetically right by SHIFT and clamp: <0 -> 0, >511 -> 511, else the value.
REQ-023 Latency SHALL be exactly 3 cycles from the accepting edge of the window-completing column to out_valid=1; the pipeline has no stall or backpressure.
REQ-024 out_valid SHALL be 1 for exactly one cycle per valid window; (WIDTH-2)*(HEIGHT-2) results per frame.
REQ-025 frame_done SHALL pulse with the result of window row=HEIGHT-1, col=WIDTH-1.
REQ-026 While out_valid=0, pix_out SHALL hold its last value.

Reset
REQ-027 Asserting reset (low) at any time, including mid-frame or with results in flight, SHALL immediately clear col, row, window, latched kernel and all pipeline valid bits; out_valid=0, frame_done=0, pix_out=0.
REQ-028 In-flight results SHALL be discarded; after release, the next accepted column is col=0, row=0 of a new frame.

Verification (WIDTH=5, HEIGHT=4, SHIFT=0 unless stated)
REQ-029 Identity kernel (k4=1, rest 0), pixel value = 10*row+col, in_valid held high -> 6 results, each equal to centre pixel (11,12,13,21,22,23); first out_valid 3 cycles after col=2,row=2 accepted; frame_done on the 6th.
REQ-030 All coefficients 7, all pixels 511 -> sum 32193 -> pix_out=511; with SHIFT=6, 503.
REQ-031 k4=-1, rest 0, pixels 100 -> pix_out=0 (negative clamp).
REQ-032 Same stream as REQ-029 with in_valid toggled 1-0-1-0 -> identical result sequence, each result 3 cycles after its completing column.
REQ-033 Change kernel to all zeros at row=2 col=1 -> all six results still per the frame-start kernel; next frame all results 0.
REQ-034 Assert reset after 3 results of frame 1 -> outputs cleared immediately, no further results from frame 1; fresh full frame after release produces 6 correct results.

Source files
------------

// File: rtl/conv_window3x3.sv
// Streaming 3x3 convolution over a row-tap image stream.
// Three pipeline stages (multiply, sum, shift+clamp) behind a 3x3 window register.
module conv_window3x3 #(
  parameter int unsigned WIDTH  = 180,
  parameter int unsigned HEIGHT = 180,
  parameter int unsigned SHIFT  = 0
) (
  input  logic        pushpixel,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [8:0]  w1,
  input  logic [8:0]  w2,
  input  logic [8:0]  w3,
  input  logic [35:0] kernel,
  output logic        out_valid,
  output logic [8:0]  pix_out,
  output logic        frame_done
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [CW-1:0] ColLast = CW'(WIDTH - 1);
  localparam logic [RW-1:0] RowLast = RW'(HEIGHT - 1);

  logic [CW-1:0]      col_q, col_d;
  logic [RW-1:0]      row_q, row_d;
  logic [8:0]         win_q [9];
  logic [8:0]         win_d [9];
  logic [35:0]        kern_q, kern_d;
  logic               v0_q, v0_d, last0_q, last0_d;
  logic signed [13:0] prod_q [9];
  logic signed [13:0] prod_d [9];
  logic signed [13:0] pix_ext [9];
  logic signed [13:0] coef_ext [9];
  logic               v1_q, last1_q;
  logic signed [17:0] sum_q, sum_d, shifted;
  logic               v2_q, last2_q;
  logic               out_valid_q, frame_done_q;
  logic [8:0]         pix_q, pix_d;

  // Window index is row*3 + col; column 2 is the newest.
  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    win_d   = win_q;
    kern_d  = kern_q;
    v0_d    = 1'b0;
    last0_d = 1'b0;
    if (in_valid) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r*3]     = win_q[r*3+1];
        win_d[r*3+1]   = win_q[r*3+2];
      end
      win_d[2] = w1;
      win_d[5] = w2;
      win_d[8] = w3;
      if (col_q == '0 && row_q == '0) kern_d = kernel;
      v0_d    = (32'(col_q) >= 32'd2) && (32'(row_q) >= 32'd2);
      last0_d = v0_d && (col_q == ColLast) && (row_q == RowLast);
      if (col_q == ColLast) begin
        col_d = '0;
        row_d = (row_q == RowLast) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 9; k++) begin
      pix_ext[k]  = {5'b0, win_q[k]};
      coef_ext[k] = {{10{kern_q[4*k+3]}}, kern_q[4*k +: 4]};
      prod_d[k]   = pix_ext[k] * coef_ext[k];
    end
  end

  always_comb begin
    sum_d = '0;
    for (int k = 0; k < 9; k++) begin
      sum_d = sum_d + {{4{prod_q[k][13]}}, prod_q[k]};
    end
  end

  always_comb begin
    shifted = sum_q >>> SHIFT;
    pix_d   = pix_q;
    if (v2_q) begin
      if (shifted[17])              pix_d = 9'd0;
      else if (shifted > 18'sd511)  pix_d = 9'd511;
      else                          pix_d = shifted[8:0];
    end
  end

  always_ff @(posedge pushpixel or negedge reset) begin
    if (!reset) begin
      col_q        <= '0;
      row_q        <= '0;
      win_q        <= '{default: '0};
      kern_q       <= '0;
      v0_q         <= 1'b0;
      last0_q      <= 1'b0;
      prod_q       <= '{default: '0};
      v1_q         <= 1'b0;
      last1_q      <= 1'b0;
      sum_q        <= '0;
      v2_q         <= 1'b0;
      last2_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      pix_q        <= '0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_q        <= win_d;
      kern_q       <= kern_d;
      v0_q         <= v0_d;
      last0_q      <= last0_d;
      prod_q       <= prod_d;
      v1_q         <= v0_q;
      last1_q      <= last0_q;
      sum_q        <= sum_d;
      v2_q         <= v1_q;
      last2_q      <= last1_q;
      out_valid_q  <= v2_q;
      frame_done_q <= v2_q && last2_q;
      pix_q        <= pix_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;
  assign pix_out    = pix_q;

endmodule

// File: tb/tb_conv_window3x3.sv
// Directed bench for conv_window3x3 on a 5x4 frame; SHIFT=0 and SHIFT=6 instances.
module tb_conv_window3x3;

  localparam int W = 5;
  localparam int H = 4;
  localparam logic [35:0] KId   = 36'h000010000;
  localparam logic [35:0] KAll7 = 36'h777777777;
  localparam logic [35:0] KNeg  = 36'h0000F0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [8:0]  w1, w2, w3;
  logic [35:0] kernel;
  logic        ov0, fd0, ov6, fd6;
  logic [8:0]  px0, px6;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fd6_cnt = 0;
  int rv[$], rf[$], rc[$], r6[$], ac[$];
  int e_id[6]   = '{11, 12, 13, 21, 22, 23};
  int e_511[6]  = '{511, 511, 511, 511, 511, 511};
  int e_zero[6] = '{0, 0, 0, 0, 0, 0};

  conv_window3x3 #(.WIDTH(W), .HEIGHT(H), .SHIFT(0)) dut (
    .pushpixel (clk),
    .reset     (rst_n),
    .in_valid  (in_valid),
    .w1        (w1),
    .w2        (w2),
    .w3        (w3),
    .kernel    (kernel),
    .out_valid (ov0),
    .pix_out   (px0),
    .frame_done(fd0)
  );

  conv_window3x3 #(.WIDTH(W), .HEIGHT(H), .SHIFT(6)) dut6 (
    .pushpixel (clk),
    .reset     (rst_n),
    .in_valid  (in_valid),
    .w1        (w1),
    .w2        (w2),
    .w3        (w3),
    .kernel    (kernel),
    .out_valid (ov6),
    .pix_out   (px6),
    .frame_done(fd6)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ov0 === 1'b1) begin
      rv.push_back(int'(px0));
      rf.push_back(int'(fd0));
      rc.push_back(cyc);
    end
    if (ov6 === 1'b1) r6.push_back(int'(px6));
    if (ov6 === 1'b1 && fd6 === 1'b1) fd6_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int pix(input int mode, input int r, input int c);
    if (r < 0) return 0;
    case (mode)
      0:       return 10 * r + c;
      1:       return 511;
      default: return 100;
    endcase
  endfunction

  // gap: idle cycle after every column; chg: zero kernel input at row 2 col 1;
  // abort_n: stop driving once that many results have been seen.
  task automatic run_frame(input logic [35:0] kern, input int mode, input int gap,
                           input int chg, input int abort_n);
    ac.delete(); rv.delete(); rf.delete(); rc.delete(); r6.delete();
    fd6_cnt = 0;
    kernel = kern;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        @(negedge clk); #1;
        if (abort_n > 0 && rv.size() >= abort_n) begin
          in_valid = 1'b0;
          return;
        end
        if (chg != 0 && r == 2 && c == 1) kernel = '0;
        w1 = 9'(pix(mode, r - 2, c));
        w2 = 9'(pix(mode, r - 1, c));
        w3 = 9'(pix(mode, r, c));
        in_valid = 1'b1;
        @(posedge clk); #1;
        if (r >= 2 && c >= 2) ac.push_back(cyc);
        if (gap != 0) begin
          @(negedge clk); #1;
          in_valid = 1'b0;
        end
      end
    end
    @(negedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    #1;
  endtask

  task automatic check_frame(input string tag, input int ev[6]);
    chk($sformatf("%s_count", tag), rv.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < rv.size() && i < ac.size()) begin
        chk($sformatf("%s_val%0d", tag, i), rv[i], ev[i]);
        chk($sformatf("%s_fd%0d", tag, i), rf[i], (i == 5) ? 1 : 0);
        chk($sformatf("%s_lat%0d", tag, i), rc[i] - ac[i], 3);
      end
    end
    chk($sformatf("%s_hold_valid", tag), ov0, 0);
    chk($sformatf("%s_hold_pix", tag), px0, ev[5]);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    w1 = '0; w2 = '0; w3 = '0;
    kernel = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", ov0, 0);
    chk("rst_pix_out", px0, 0);
    chk("rst_frame_done", fd0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_frame(KId, 0, 0, 0, 0);
    check_frame("ident", e_id);

    run_frame(KAll7, 1, 0, 0, 0);
    check_frame("sat", e_511);
    chk("shift6_count", r6.size(), 6);
    for (int i = 0; i < r6.size(); i++) chk($sformatf("shift6_val%0d", i), r6[i], 503);
    chk("shift6_fd_count", fd6_cnt, 1);

    run_frame(KNeg, 2, 0, 0, 0);
    check_frame("negclamp", e_zero);

    run_frame(KId, 0, 1, 0, 0);
    check_frame("gap", e_id);

    run_frame(KId, 0, 0, 1, 0);
    check_frame("kchg", e_id);
    run_frame('0, 0, 0, 0, 0);
    check_frame("knext", e_zero);

    run_frame(KId, 0, 0, 0, 3);
    chk("abort_seen", rv.size(), 3);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", ov0, 0);
    chk("midrst_pix_out", px0, 0);
    chk("midrst_frame_done", fd0, 0);
    repeat (4) @(negedge clk);
    chk("midrst_no_more", rv.size(), 3);
    rst_n = 1'b1;
    run_frame(KId, 0, 0, 0, 0);
    check_frame("postrst", e_id);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
